// File: rtl/two_five_pkg.sv
// rtl/two_five_pkg.sv - shared types and 2-of-5 code constants for the serial frame controller
//
// Purpose: FSM state enum, code width and the ten digit codes plus the
// substitute code used for non-BCD digit values.
// Ports: none (package).

package two_five_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int CODE_W = 5;

  localparam logic [CODE_W-1:0] CODE_0       = 5'b01100;
  localparam logic [CODE_W-1:0] CODE_1       = 5'b11000;
  localparam logic [CODE_W-1:0] CODE_2       = 5'b10100;
  localparam logic [CODE_W-1:0] CODE_3       = 5'b10010;
  localparam logic [CODE_W-1:0] CODE_4       = 5'b01010;
  localparam logic [CODE_W-1:0] CODE_5       = 5'b00110;
  localparam logic [CODE_W-1:0] CODE_6       = 5'b10001;
  localparam logic [CODE_W-1:0] CODE_7       = 5'b01001;
  localparam logic [CODE_W-1:0] CODE_8       = 5'b00101;
  localparam logic [CODE_W-1:0] CODE_9       = 5'b00011;
  localparam logic [CODE_W-1:0] CODE_INVALID = 5'b11011;

endpackage

// File: rtl/two_of_five_lut.sv
// rtl/two_of_five_lut.sv - combinational BCD digit to 2-of-5 code map
//
// Purpose: maps one 4-bit digit to its 5-bit 2-of-5 code; values above 9
// map to CODE_INVALID.
// Ports:
//   digit  in  4       BCD digit
//   code   out CODE_W  2-of-5 code, bit 4 is transmitted first

module two_of_five_lut
  import two_five_pkg::*;
(
  input  logic [3:0]        digit,
  output logic [CODE_W-1:0] code
);

  always_comb begin
    code = CODE_INVALID;
    unique case (digit)
      4'd0:    code = CODE_0;
      4'd1:    code = CODE_1;
      4'd2:    code = CODE_2;
      4'd3:    code = CODE_3;
      4'd4:    code = CODE_4;
      4'd5:    code = CODE_5;
      4'd6:    code = CODE_6;
      4'd7:    code = CODE_7;
      4'd8:    code = CODE_8;
      4'd9:    code = CODE_9;
      default: code = CODE_INVALID;
    endcase
  end

endmodule

// File: rtl/two_five_ser_ctrl.sv
// rtl/two_five_ser_ctrl.sv - BCD frame to serial 2-of-5 bitstream controller
//
// Purpose: accepts an NDIGITS-digit BCD frame on a valid/ready handshake and
// shifts out the 2-of-5 code of each digit (digit 0 first, code bit 4 first)
// under ser_ready backpressure, then pulses done for one cycle.
// Build option: TWO_FIVE_CHECK_EN - when defined, frames holding a digit
// above 9 are rejected at accept and go straight to DONE with err set.
// Ports:
//   clk        in   1           rising-edge clock
//   reset      in   1           synchronous active-high reset
//   in_valid   in   1           producer offers a frame
//   in_bcd     in   4*NDIGITS   BCD frame, digit 0 in the top nibble
//   in_ready   out  1           frame can be accepted (IDLE or DONE)
//   ser_ready  in   1           downstream consumes the current bit
//   ser_en     out  1           ser_out carries a valid bit
//   ser_out    out  1           serial data, 0 when ser_en=0
//   done       out  1           one-cycle end-of-frame pulse
//   err        out  1           last accepted frame had a digit above 9

module two_five_ser_ctrl
  import two_five_pkg::*;
#(
  parameter int NDIGITS = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [4*NDIGITS-1:0] in_bcd,
  output logic                 in_ready,
  input  logic                 ser_ready,
  output logic                 ser_en,
  output logic                 ser_out,
  output logic                 done,
  output logic                 err
);

  localparam int FW = 4 * NDIGITS;
  localparam int DW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam logic [DW-1:0] DIG_LAST = DW'(NDIGITS - 1);

  state_t            state, state_n;
  logic [FW-1:0]     frame;
  logic [2:0]        bit_cnt;
  logic [DW-1:0]     dig_cnt;
  logic              err_q;
  logic              accept;
  logic              frame_bad;
  logic              last_digit;
  logic [CODE_W-1:0] cur_code;

  assign in_ready   = (state == IDLE) || (state == DONE);
  assign accept     = in_valid && in_ready;
  assign last_digit = (dig_cnt == DIG_LAST);

  always_comb begin
    frame_bad = 1'b0;
    for (int i = 0; i < NDIGITS; i++) begin
      if (in_bcd[4*i +: 4] > 4'd9) frame_bad = 1'b1;
    end
  end

  // The frame register shifts left one digit as each digit completes, so the
  // digit being sent always sits in the top nibble.
  two_of_five_lut u_lut (
    .digit (frame[FW-1 -: 4]),
    .code  (cur_code)
  );

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE, DONE: begin
        if (accept) begin
          state_n = SEND;
`ifdef TWO_FIVE_CHECK_EN
          if (frame_bad) state_n = DONE;
`endif
        end else begin
          state_n = IDLE;
        end
      end
      SEND: begin
        if (ser_ready && bit_cnt == 3'd4 && last_digit) state_n = DONE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      frame   <= '0;
      bit_cnt <= 3'd0;
      dig_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        frame   <= in_bcd;
        bit_cnt <= 3'd0;
        dig_cnt <= '0;
        err_q   <= frame_bad;
      end else if (state == SEND && ser_ready) begin
        if (bit_cnt == 3'd4) begin
          bit_cnt <= 3'd0;
          // Counters stop at their terminal values on the final digit.
          if (!last_digit) begin
            dig_cnt <= dig_cnt + DW'(1);
            frame   <= frame << 4;
          end
        end else begin
          bit_cnt <= bit_cnt + 3'd1;
        end
      end
    end
  end

  assign ser_en  = (state == SEND);
  assign ser_out = ser_en & cur_code[3'd4 - bit_cnt];
  assign done    = (state == DONE);
  assign err     = err_q;

endmodule

// File: tb/tb_two_five_ser_ctrl.sv
// tb/tb_two_five_ser_ctrl.sv - self-checking randomized bench for two_five_ser_ctrl

module tb_two_five_ser_ctrl;

  localparam int N = 4;
  localparam logic [4:0] CODE_TAB [10] = '{
    5'b01100, 5'b11000, 5'b10100, 5'b10010, 5'b01010,
    5'b00110, 5'b10001, 5'b01001, 5'b00101, 5'b00011
  };

  logic           clk = 1'b0;
  logic           reset;
  logic           in_valid;
  logic [4*N-1:0] in_bcd;
  logic           in_ready;
  logic           ser_ready;
  logic           ser_en;
  logic           ser_out;
  logic           done;
  logic           err;

  int   checks = 0;
  int   errors = 0;
  logic exp_err;
  bit   exp_q[$];

  always #5 clk = ~clk;

  two_five_ser_ctrl #(.NDIGITS(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_bcd    (in_bcd),
    .in_ready  (in_ready),
    .ser_ready (ser_ready),
    .ser_en    (ser_en),
    .ser_out   (ser_out),
    .done      (done),
    .err       (err)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic bit has_bad(input logic [4*N-1:0] f);
    for (int d = 0; d < N; d++) begin
      if (f[4*d +: 4] > 4'd9) return 1'b1;
    end
    return 1'b0;
  endfunction

  // Expected bitstream: digit 0 (top nibble) first, code MSB first.
  task automatic build(input logic [4*N-1:0] f);
    logic [3:0] dig;
    logic [4:0] c;
    exp_q.delete();
`ifdef TWO_FIVE_CHECK_EN
    if (has_bad(f)) return;
`endif
    for (int d = 0; d < N; d++) begin
      dig = f[4*(N-1-d) +: 4];
      c   = (dig > 4'd9) ? 5'b11011 : CODE_TAB[dig];
      for (int b = 4; b >= 0; b--) exp_q.push_back(c[b]);
    end
  endtask

  // Called at a sampling point in IDLE or DONE; the accept happens on the next edge.
  task automatic accept(input string tag, input logic [4*N-1:0] f);
    in_valid = 1'b1;
    in_bcd   = f;
    check($sformatf("%s_in_ready", tag), in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_bcd   = 16'($urandom);
    exp_err  = has_bad(f);
    build(f);
  endtask

  // mode 0: ready always, no in_valid; 1: random ready and in_valid;
  // 2: three stall cycles on bit 7; 3: ready always, random in_valid.
  task automatic stream(input string tag, input int mode, input int abort_at);
    int popped = 0;
    int stall_left = 3;
    int iter = 0;
    while (exp_q.size() > 0) begin
      if (iter >= 400) begin
        check($sformatf("%s_timeout", tag), 1, 0);
        exp_q.delete();
        break;
      end
      if (abort_at >= 0 && iter == abort_at) begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        ser_ready = 1'($urandom);
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
        exp_err = 1'b0;
        @(negedge clk);
        check($sformatf("%s_rst_in_ready", tag), in_ready, 1);
        check($sformatf("%s_rst_ser_en", tag), ser_en, 0);
        check($sformatf("%s_rst_ser_out", tag), ser_out, 0);
        check($sformatf("%s_rst_done", tag), done, 0);
        check($sformatf("%s_rst_err", tag), err, 0);
        return;
      end
      case (mode)
        1:       ser_ready = ($urandom_range(0, 3) != 0);
        2: begin
          if (popped == 7 && stall_left > 0) begin
            ser_ready = 1'b0;
            stall_left--;
          end else begin
            ser_ready = 1'b1;
          end
        end
        default: ser_ready = 1'b1;
      endcase
      in_valid = (mode == 1 || mode == 3) ? 1'($urandom_range(0, 1)) : 1'b0;
      in_bcd   = 16'($urandom);
      @(negedge clk);
      check($sformatf("%s_ser_en_b%0d", tag, popped), ser_en, 1);
      check($sformatf("%s_ser_out_b%0d", tag, popped), ser_out, exp_q[0]);
      check($sformatf("%s_busy_in_ready", tag), in_ready, 0);
      check($sformatf("%s_busy_done", tag), done, 0);
      check($sformatf("%s_busy_err", tag), err, exp_err);
      @(posedge clk);
      #1;
      if (ser_ready) begin
        void'(exp_q.pop_front());
        popped++;
      end
      iter++;
    end
    in_valid  = 1'b0;
    ser_ready = 1'($urandom);
    @(negedge clk);
    check($sformatf("%s_done", tag), done, 1);
    check($sformatf("%s_done_ser_en", tag), ser_en, 0);
    check($sformatf("%s_done_ser_out", tag), ser_out, 0);
    check($sformatf("%s_done_in_ready", tag), in_ready, 1);
    check($sformatf("%s_done_err", tag), err, exp_err);
  endtask

  task automatic idle(input string tag, input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
      ser_ready = 1'($urandom);
      @(negedge clk);
      check($sformatf("%s_idle_done", tag), done, 0);
      check($sformatf("%s_idle_in_ready", tag), in_ready, 1);
      check($sformatf("%s_idle_ser_en", tag), ser_en, 0);
      check($sformatf("%s_idle_ser_out", tag), ser_out, 0);
      check($sformatf("%s_idle_err", tag), err, exp_err);
    end
  endtask

  initial begin
    logic [4*N-1:0] f;
    reset     = 1'b1;
    in_valid  = 1'b0;
    ser_ready = 1'b0;
    in_bcd    = '0;
    exp_err   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("reset_in_ready", in_ready, 1);
    check("reset_ser_en", ser_en, 0);
    check("reset_ser_out", ser_out, 0);
    check("reset_done", done, 0);
    check("reset_err", err, 0);

    accept("f0123", 16'h0123);
    stream("f0123", 0, -1);
    idle("f0123", 1);

    accept("stall7", 16'h0123);
    stream("stall7", 2, -1);
    idle("stall7", 1);

    accept("f9a05", 16'h9A05);
    stream("f9a05", 0, -1);
    idle("f9a05", 2);

    accept("abort", 16'h0123);
    stream("abort", 0, 6);
    accept("restart", 16'h0123);
    stream("restart", 0, -1);
    idle("restart", 1);

    accept("b2b_a", 16'h4567);
    stream("b2b_a", 3, -1);
    accept("b2b_b", 16'h8900);
    stream("b2b_b", 3, -1);
    idle("b2b", 1);

    for (int k = 0; k < 25; k++) begin
      for (int d = 0; d < N; d++) begin
        f[4*d +: 4] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15))
                                                  : 4'($urandom_range(0, 9));
      end
      accept($sformatf("rnd%0d", k), f);
      stream($sformatf("rnd%0d", k), 1, -1);
      if ($urandom_range(0, 1) == 1) idle($sformatf("rnd%0d", k), $urandom_range(1, 2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

endmodule

// File: doc/two_five_ser_ctrl.md
# two_five_ser_ctrl

Frame controller that accepts a multi-digit BCD word through a valid/ready handshake and emits the 2-of-5 encoding of each digit as a serial bitstream. It sits between a BCD producer and a bit-serial line driver. It sequences digits through a combinational 2-of-5 lookup, shifts bits out under downstream backpressure, and signals frame completion.

## Interface
- NDIGITS, default 4: BCD digits per frame, range 1 to 8.
- clk  in  1  rising-edge clock; the only clock domain.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  producer offers a frame on in_bcd.
- in_bcd  in  4*NDIGITS  BCD frame; digit 0 is in_bcd[4*NDIGITS-1 -: 4] and is sent first.
- in_ready  out  1  controller can accept a frame.
- ser_ready  in  1  downstream consumes the current bit this cycle.
- ser_en  out  1  ser_out carries a valid bit.
- ser_out  out  1  serial data; forced to 0 whenever ser_en=0.
- done  out  1  one-cycle pulse after the last bit of a frame is consumed.
- err  out  1  at least one digit of the most recent frame was greater than 9; held until the next accept.

## Operation
- States: IDLE, SEND, DONE.
- IDLE:
  - in_ready=1, ser_en=0.
  - On in_valid && in_ready: latch in_bcd into the frame register, clear dig_cnt and bit_cnt, compute err, go to SEND.
- SEND:
  - ser_en=1. ser_out = code(digit[dig_cnt])[4 - bit_cnt], so bit 4 is sent first.
  - On ser_ready: increment bit_cnt. At bit_cnt=4, wrap bit_cnt to 0 and increment dig_cnt. When dig_cnt=NDIGITS-1 and bit_cnt=4, go to DONE.
  - When ser_ready=0: the bit, counters and state hold unchanged.
- DONE: done=1 for exactly one cycle. in_ready=1 in this cycle, and an accept here starts the next frame (transition to SEND).
- Code map:
  - 0→01100, 1→11000, 2→10100, 3→10010, 4→01010.
  - 5→00110, 6→10001, 7→01001, 8→00101, 9→00011.
  - Any value greater than 9 → 11011.
- in_valid outside IDLE or DONE is ignored. in_bcd is sampled only on accept.
- Width rules: bit_cnt is 3 bits; dig_cnt is $clog2(NDIGITS) bits, minimum 1. Counters never exceed their terminal values.
- Reset, including mid-frame: state=IDLE, frame discarded, counters=0, in_ready=1, ser_en=0, ser_out=0, done=0, err=0.

## Timing
- Accept in cycle T. The first bit is valid (ser_en=1) in T+1.
- With ser_ready held at 1: bits occupy T+1 through T+5*NDIGITS, done is high in T+5*NDIGITS+1, and the earliest next accept is also T+5*NDIGITS+1.
- Each cycle of ser_ready=0 during SEND adds exactly one cycle of latency.
- All outputs are registered or decoded from registered state only. There is no combinational path from in_valid or ser_ready to any output.
- Throughput: one frame per 5*NDIGITS+1 cycles with no stalls.

## Configuration
- TWO_FIVE_CHECK_EN defined:
  - A frame containing any digit greater than 9 is rejected at accept.
  - The controller goes directly to DONE with no ser_en cycles. done pulses in T+1 and err=1.
- TWO_FIVE_CHECK_EN undefined:
  - Invalid digits are transmitted as 11011.
  - err is still set, and the frame length is unchanged.

## Structure
- Package two_five_pkg:
  - State enum.
  - The ten digit codes.
  - CODE_INVALID = 5'b11011.
  - CODE_W = 5.
- Sub-module two_of_five_lut: purely combinational 4-bit to 5-bit map using the code table above. It is instantiated once and indexed by the current digit. The controller holds all sequential logic.

## Test plan
- NDIGITS=4, in_bcd=16'h0123, ser_ready=1 → ser_out stream 01100 11000 10100 10010 over cycles T+1 to T+20; done in T+21; err=0.
- Same frame with ser_ready=0 for 3 cycles at bit 7 → bit 7 is held stable for 4 cycles; done in T+24; stream unchanged.
- in_bcd=16'h9A05, macro undefined → stream 00011 11011 01100 00110; err=1.
- Same frame, macro defined → no ser_en cycles; done in T+1; err=1.
- reset asserted at cycle T+7 of a frame → next cycle: in_ready=1, ser_en=0, ser_out=0, done=0; a fresh accept restarts from digit 0 bit 4.
- Back-to-back frames 16'h4567 then 16'h8900, with in_valid held and also pulsed during SEND → second accept occurs in the DONE cycle (T+21), and no frame is accepted during SEND.
